tnn_neuron_seq: RTL and testbench

// - Sequential, parametrised ternary-NN neuron. Streams N input activations (IN_W-bit unsigned), one per beat.
// - Each beat carries a ternary weight {-1,0,+1}. The block accumulates the signed weighted sum.
// - On the last beat it emits one output bit: (sum > THRESH).
// - Successor to the fixed 5-input/3-bit combinational comparator neurons. Sits between the activation

---
 rtl/tnn_neuron_seq.sv | 122 ++++++++++++
 tb/tb_tnn_neuron_seq.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/tnn_neuron_seq.sv
// Sequential ternary-NN neuron: streams up to N_MAX weighted activations and emits (sum > THRESH).
// Optional build macro TNN_MARGIN_OUT_EN adds the signed out_margin result port (final acc - THRESH).
module tnn_neuron_seq #(
   parameter int IN_W   = 3,
   parameter int N_MAX  = 5,
   parameter int THRESH = 0,
   localparam int ACC_W = IN_W + $clog2(N_MAX) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [IN_W-1:0]         in_data,
   input  logic [1:0]              in_weight,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
`ifdef TNN_MARGIN_OUT_EN
   output logic signed [ACC_W-1:0] out_margin,
`endif
   output logic                    out_bit
);

   localparam int CNT_W = $clog2(N_MAX + 1);
   localparam logic signed [ACC_W-1:0] THRESH_C = ACC_W'(THRESH);
   localparam logic [CNT_W-1:0]        LAST_IDX = CNT_W'(N_MAX - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                   state_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic [CNT_W-1:0]         cnt_q;
   logic                     in_ready_q;
   logic                     out_valid_q;
   logic                     out_bit_q;
`ifdef TNN_MARGIN_OUT_EN
   logic signed [ACC_W-1:0]  margin_q;
`endif

   logic signed [ACC_W-1:0]  data_ext_d;
   logic signed [ACC_W-1:0]  term_d;
   logic signed [ACC_W-1:0]  sum_d;
   logic                     end_beat_d;
   logic                     in_xfer_d;

   // Activation is unsigned, so zero-extend before applying the ternary sign.
   always_comb begin
      data_ext_d = signed'({{(ACC_W - IN_W){1'b0}}, in_data});
      term_d     = '0;
      case (in_weight)
         2'b01:   term_d = data_ext_d;
         2'b11:   term_d = -data_ext_d;
         default: term_d = '0;
      endcase
      sum_d      = (state_q == S_IDLE) ? term_d : acc_q + term_d;
      end_beat_d = in_last || (cnt_q == LAST_IDX);
      in_xfer_d  = in_valid && in_ready_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_bit_q   <= 1'b0;
`ifdef TNN_MARGIN_OUT_EN
         margin_q    <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE, S_ACC: begin
               if (in_xfer_d) begin
                  acc_q <= sum_d;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (end_beat_d) begin
                     // Result is captured from the final sum so it stays stable through DONE.
                     state_q     <= S_DONE;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                     out_bit_q   <= (sum_d > THRESH_C);
`ifdef TNN_MARGIN_OUT_EN
                     margin_q    <= sum_d - THRESH_C;
`endif
                  end else begin
                     state_q <= S_ACC;
                  end
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_q     <= S_IDLE;
                  acc_q       <= '0;
                  cnt_q       <= '0;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               acc_q       <= '0;
               cnt_q       <= '0;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_bit   = out_bit_q;
`ifdef TNN_MARGIN_OUT_EN
   assign out_margin = margin_q;
`endif

endmodule

// File: tb/tb_tnn_neuron_seq.sv
// Directed bench for tnn_neuron_seq with default parameters (IN_W=3, N_MAX=5, THRESH=0).
// Honours TNN_MARGIN_OUT_EN to also check out_margin.
module tb_tnn_neuron_seq;

   localparam logic [1:0] WP = 2'b01;
   localparam logic [1:0] WN = 2'b11;
   localparam logic [1:0] WZ = 2'b00;
   localparam logic [1:0] WR = 2'b10;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_data;
   logic [1:0]  in_weight;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic        out_bit;
`ifdef TNN_MARGIN_OUT_EN
   logic signed [6:0] out_margin;
`endif

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;

   tnn_neuron_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_weight (in_weight),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef TNN_MARGIN_OUT_EN
      .out_margin(out_margin),
`endif
      .out_bit   (out_bit)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // One accepted beat; afterwards the inputs carry junk with in_valid low.
   task automatic beat(input logic [1:0] w, input logic [2:0] d, input logic last);
      check("in_ready_before_beat", in_ready, 1);
      in_valid  = 1'b1;
      in_weight = w;
      in_data   = d;
      in_last   = last;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      in_weight = WP;
      in_data   = 3'd5;
      in_last   = 1'b1;
   endtask

   task automatic expect_result(input string tag, input logic exp_bit, input int exp_margin);
      check({tag, "_out_valid"}, out_valid, 1);
      check({tag, "_out_bit"}, out_bit, exp_bit);
      check({tag, "_in_ready_low"}, in_ready, 0);
`ifdef TNN_MARGIN_OUT_EN
      check({tag, "_out_margin"}, out_margin, exp_margin);
`else
      if (exp_margin == 12345) $display("unused margin");
`endif
   endtask

   task automatic accept(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      $display("result %s accepted: out_bit=%0d", tag, out_bit);
      check({tag, "_accept_out_valid"}, out_valid, 0);
      check({tag, "_accept_in_ready"}, in_ready, 1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_weight = '0; in_last = 1'b0; out_ready = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      check("reset_out_valid", out_valid, 0);
      check("reset_out_bit", out_bit, 0);
      check("reset_in_ready", in_ready, 1);
`ifdef TNN_MARGIN_OUT_EN
      check("reset_out_margin", out_margin, 0);
`endif

      // -3 +1 +2 -2 +3 = +1
      beat(WN, 3'd3, 1'b0); beat(WP, 3'd1, 1'b0); beat(WP, 3'd2, 1'b0); beat(WN, 3'd2, 1'b0);
      check("s1_no_valid_before_last", out_valid, 0);
      beat(WP, 3'd3, 1'b1);
      expect_result("s1", 1'b1, 1);
      accept("s1");

      // Same with beat 5 weight 0 and an idle gap in the middle: -2
      beat(WN, 3'd3, 1'b0); beat(WP, 3'd1, 1'b0);
      @(posedge clk); #1;
      beat(WP, 3'd2, 1'b0); beat(WN, 3'd2, 1'b0); beat(WZ, 3'd3, 1'b1);
      expect_result("s2", 1'b0, -2);
      accept("s2");

      // Sum exactly at threshold, ended early by in_last on beat 2
      beat(WP, 3'd3, 1'b0); beat(WN, 3'd3, 1'b1);
      expect_result("zero", 1'b0, 0);
      accept("zero");

      // Backpressure with an offered beat that must not be taken
      beat(WN, 3'd3, 1'b0); beat(WP, 3'd1, 1'b0); beat(WP, 3'd2, 1'b0); beat(WN, 3'd2, 1'b0); beat(WP, 3'd3, 1'b1);
      in_valid = 1'b1; in_weight = WP; in_data = 3'd7; in_last = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("hold_out_valid", out_valid, 1);
         check("hold_out_bit", out_bit, 1);
         check("hold_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      accept("hold");

      // Truncation at N_MAX without in_last: +35 then -35
      beat(WP, 3'd7, 1'b0); beat(WP, 3'd7, 1'b0); beat(WP, 3'd7, 1'b0); beat(WP, 3'd7, 1'b0);
      check("trunc_pos_no_valid", out_valid, 0);
      beat(WP, 3'd7, 1'b0);
      expect_result("trunc_pos", 1'b1, 35);
      accept("trunc_pos");
      for (int i = 0; i < 5; i++) beat(WN, 3'd7, 1'b0);
      expect_result("trunc_neg", 1'b0, -35);
      accept("trunc_neg");

      // Reserved weight contributes zero
      beat(WN, 3'd1, 1'b0); beat(WR, 3'd7, 1'b1);
      expect_result("resv_a", 1'b0, -1);
      accept("resv_a");
      beat(WP, 3'd1, 1'b0); beat(WR, 3'd7, 1'b1);
      expect_result("resv_b", 1'b1, 1);
      accept("resv_b");

      // Reset mid-evaluation discards the partial sum (+21)
      beat(WP, 3'd7, 1'b0); beat(WP, 3'd7, 1'b0); beat(WP, 3'd7, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_mid_out_valid", out_valid, 0);
      check("rst_mid_in_ready", in_ready, 1);
      @(posedge clk); #1;
      check("rst_mid_out_valid_later", out_valid, 0);
      beat(WN, 3'd3, 1'b0); beat(WP, 3'd1, 1'b0); beat(WP, 3'd2, 1'b0); beat(WN, 3'd2, 1'b0); beat(WZ, 3'd3, 1'b1);
      expect_result("post_rst", 1'b0, -2);
      accept("post_rst");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
